exc3_serial_rx: RTL and testbench

- Serial receiver that assembles a frame of DIGITS excess-3 digits from a 1-bit line.
- Checks each digit for a legal excess-3 code and presents the parallel word with a valid/ready handshake.
- Sits directly upstream of the excess-3-to-BCD converters: each 4-bit slice of a_out drives one converter's input.

---
 rtl/exc3_serial_rx.sv | 131 +++++++++++++
 tb/tb_exc3_serial_rx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc3_serial_rx.sv
// Serial excess-3 frame receiver: shifts DIGITS digits in LSB first,
// flags illegal codes and holds the word behind a valid/ready handshake.
module exc3_serial_rx #(
    parameter int DIGITS = 2,
    parameter int CW     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sin,
    input  logic              sin_en,
    output logic [4*DIGITS-1:0] a_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              code_err,
    output logic              overrun,
    output logic              busy
);
    localparam int W = 4 * DIGITS;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  a_shift;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          ovr_q, ovr_d;
    logic          busy_q, busy_d;

    function automatic logic word_err(input logic [W-1:0] w);
        logic e;
        e = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w[4*k +: 4] < 4'd3 || w[4*k +: 4] > 4'd12) begin
                e = 1'b1;
            end
        end
        return e;
    endfunction

    always_comb begin
        a_shift = a_q;
        for (int i = 0; i < W; i++) begin
            if (cnt_q == CW'(i)) begin
                a_shift[i] = sin;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        valid_d = valid_q;
        err_d   = err_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    a_d     = '0;
                end
            end
            SHIFT: begin
                if (start) begin
                    cnt_d = '0;
                    a_d   = '0;
                end else if (sin_en) begin
                    a_d   = a_shift;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        err_d   = word_err(a_shift);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    ovr_d   = 1'b0;
                    state_d = start ? SHIFT : IDLE;
                    if (start) begin
                        cnt_d = '0;
                        a_d   = '0;
                    end
                end else if (sin_en) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign a_out     = a_q;
    assign out_valid = valid_q;
    assign code_err  = err_q;
    assign overrun   = ovr_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_exc3_serial_rx.sv
// Self-checking bench for exc3_serial_rx (DIGITS=2): directed scenarios
// plus randomized frames checked against an arithmetic reference model.
module tb_exc3_serial_rx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sin;
    logic       sin_en;
    logic [7:0] a_out;
    logic       out_valid;
    logic       out_ready;
    logic       code_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;

    exc3_serial_rx #(.DIGITS(2), .CW(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sin      (sin),
        .sin_en   (sin_en),
        .a_out    (a_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .code_err (code_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference: a frame is illegal if either decimal-position nibble,
    // taken arithmetically, falls outside 3..12.
    function automatic logic exp_err(input int w);
        int d0, d1;
        d0 = w % 16;
        d1 = (w / 16) % 16;
        return (d0 < 3 || d0 > 12 || d1 < 3 || d1 > 12);
    endfunction

    function automatic logic bit_of(input int w, input int i);
        return ((w >> i) & 1) != 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic shift_bits(input int w, input int lo, input int hi,
                              input int gap);
        for (int i = lo; i <= hi; i++) begin
            sin    = bit_of(w, i);
            sin_en = 1'b1;
            tick();
            sin_en = 1'b0;
            if (i < hi) repeat (gap) tick();
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b1;
        sin    = 1'b1;
        sin_en = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        start = 1'b0; sin = 1'b0; sin_en = 1'b0; out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (a_out !== 8'h00) begin
            errors++; $display("FAIL reset_a_out got=%h exp=00", a_out);
        end
        checks++;
        if ({out_valid, code_err, overrun, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {out_valid, code_err, overrun, busy});
        end
        tick();
    endtask

    task automatic test_basic();
        start_frame();
        shift_bits(8'hC8, 0, 6, 0);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_pre_last valid=%b busy=%b exp valid=0 busy=1",
                     out_valid, busy);
        end
        shift_bits(8'hC8, 7, 7, 0);
        checks++;
        if (out_valid !== 1'b1 || a_out !== 8'hC8 || code_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_frame valid=%b a=%h err=%b exp 1 c8 0",
                     out_valid, a_out, code_err);
        end
        accept();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || code_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept valid=%b busy=%b err=%b exp 0 0 0",
                     out_valid, busy, code_err);
        end
    endtask

    task automatic test_code_err();
        int words[2] = '{8'h50, 8'h5D};
        foreach (words[j]) begin
            start_frame();
            shift_bits(words[j], 0, 7, 1);
            checks++;
            if (out_valid !== 1'b1 || a_out !== 8'(words[j]) ||
                code_err !== 1'b1) begin
                errors++;
                $display("FAIL code_err_%0d valid=%b a=%h err=%b exp 1 %h 1",
                         j, out_valid, a_out, code_err, 8'(words[j]));
            end
            accept();
            checks++;
            if (code_err !== 1'b0) begin
                errors++;
                $display("FAIL code_err_clear_%0d got=%b exp=0", j, code_err);
            end
        end
    endtask

    task automatic test_backpressure();
        start_frame();
        shift_bits(8'h43, 0, 7, 0);
        for (int c = 0; c < 5; c++) begin
            sin    = 1'b1;
            sin_en = (c == 1 || c == 3);
            start  = (c == 2);
            tick();
            sin_en = 1'b0;
            start  = 1'b0;
            checks++;
            if (a_out !== 8'h43 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_stable_%0d a=%h valid=%b exp 43 1",
                         c, a_out, out_valid);
            end
        end
        checks++;
        if (overrun !== 1'b1 || code_err !== 1'b0) begin
            errors++;
            $display("FAIL overrun_set ovr=%b err=%b exp 1 0",
                     overrun, code_err);
        end
        accept();
        checks++;
        if (overrun !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear ovr=%b valid=%b busy=%b exp 0 0 0",
                     overrun, out_valid, busy);
        end
    endtask

    task automatic test_restart();
        start_frame();
        shift_bits(8'hFF, 0, 2, 0);
        start  = 1'b1;
        sin    = 1'b1;
        sin_en = 1'b1;
        tick();
        start  = 1'b0;
        sin_en = 1'b0;
        shift_bits(8'h96, 0, 7, 0);
        checks++;
        if (out_valid !== 1'b1 || a_out !== 8'h96 || code_err !== 1'b0) begin
            errors++;
            $display("FAIL restart valid=%b a=%h err=%b exp 1 96 0",
                     out_valid, a_out, code_err);
        end
        accept();
    endtask

    task automatic test_reset_mid();
        start_frame();
        shift_bits(8'hFF, 0, 4, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (a_out !== 8'h00 || {out_valid, code_err, overrun, busy} !== 4'b0)
        begin
            errors++;
            $display("FAIL reset_mid a=%h flags=%b exp 00 0000",
                     a_out, {out_valid, code_err, overrun, busy});
        end
        shift_bits(8'hFF, 0, 7, 0);
        tick();
        checks++;
        if (a_out !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_sin a=%h valid=%b busy=%b exp 00 0 0",
                     a_out, out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        start_frame();
        shift_bits(8'h75, 0, 7, 0);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy busy=%b valid=%b exp 1 0",
                     busy, out_valid);
        end
        shift_bits(8'h3C, 0, 7, 0);
        checks++;
        if (out_valid !== 1'b1 || a_out !== 8'h3C || code_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_frame valid=%b a=%h err=%b exp 1 3c 0",
                     out_valid, a_out, code_err);
        end
        accept();
    endtask

    task automatic test_random();
        int w, gap, wait_n;
        for (int n = 0; n < 24; n++) begin
            w      = int'($urandom_range(0, 255));
            gap    = int'($urandom_range(0, 2));
            wait_n = int'($urandom_range(0, 3));
            start_frame();
            shift_bits(w, 0, 7, gap);
            repeat (wait_n) tick();
            checks++;
            if (out_valid !== 1'b1 || a_out !== 8'(w) ||
                code_err !== exp_err(w)) begin
                errors++;
                $display("FAIL rand_%0d valid=%b a=%h err=%b exp 1 %h %b",
                         n, out_valid, a_out, code_err, 8'(w), exp_err(w));
            end
            accept();
            checks++;
            if (out_valid !== 1'b0 || overrun !== 1'b0) begin
                errors++;
                $display("FAIL rand_accept_%0d valid=%b ovr=%b exp 0 0",
                         n, out_valid, overrun);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sin = 1'b0;
        sin_en = 1'b0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_code_err();
        test_backpressure();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
